ft232h_cmd_dispatch: RTL and testbench
======================================

// Module: ft232h_cmd_dispatch
// PURPOSE
//  Consumes 5-byte host packets (8-bit cmd + 32-bit data, one-cycle ready pulse) from the FT232H
//  packet reader. Decodes each packet into register writes or register read-backs on an NREG x 32
//  parameter bank. Read-back and ack responses are serialised as bytes to the FT232H write path.
// PARAMETERS
//  NREG    16  number of 32-bit parameter registers (2..2**ADDR_W)
//  ADDR_W  4   register address bits, taken from cmd[ADDR_W-1:0] (ADDR_W<=6)
//  ACK_EN  1   1: every accepted write emits a 1-byte ack (= cmd); 0: writes are silent
// PORTS
//  i_clk         in   1        system clock
//  i_rst         in   1        synchronous reset, active-high
//  i_cmd         in   8        packet command byte, valid with i_data_ready
//  i_data        in   32       packet payload, MSB byte received first, valid with i_data_ready
//  i_data_ready  in   1        one-cycle packet strobe
//  o_reg_flat    out  NREG*32  register bank; reg k = o_reg_flat[32k+31:32k]
//  o_reg_wr_stb  out  NREG     one-hot, one-cycle pulse on the cycle after reg k updates
//  o_tx_byte     out  8        response byte to FT232H writer
//  o_tx_valid    out  1        o_tx_byte valid; held with byte stable until accepted
//  i_tx_ready    in   1        writer accepts byte when o_tx_valid & i_tx_ready
//  o_busy        out  1        response transmit in progress, or pending slot occupied
//  o_err_cnt     out  16       saturating count of rejected/dropped packets
// BEHAVIOUR
//  Reset (sync, i_rst=1 at edge): all regs 0, o_reg_wr_stb 0, o_tx_valid 0, o_tx_byte 0,
//   o_busy 0, o_err_cnt 0, pending slot empty, TX FSM -> IDLE. Mid-transmit reset aborts the
//   response; no partial byte is re-sent after reset.
//  Decode on i_data_ready (opcode = cmd[7:6]):
//   2'b00 WRITE: addr<NREG -> reg[addr]<=i_data at that edge; wr_stb[addr] next cycle;
//     if ACK_EN, queue 1-byte response {cmd}.
//   2'b01 READ: addr<NREG -> snapshot reg[addr] at that edge; queue 5-byte response
//     {cmd, d[31:24], d[23:16], d[15:8], d[7:0]}.
//   2'b1x, or addr>=NREG, or cmd[5:ADDR_W]!=0: rejected, no reg change, no response, err_cnt+1.
//  Writes update the bank immediately regardless of TX state; only responses are queued.
//  Response queue: one active response (TX FSM) + one pending slot.
//   Response queued while TX IDLE -> loads into TX directly; first o_tx_valid next cycle.
//   TX busy, pending empty -> goes to pending. Pending full -> dropped, err_cnt+1
//     (register write of a dropped WRITE ack still takes effect).
//   Same cycle as last byte accepted: pending (if any) moves to TX and the new response
//     enters pending; no drop, no idle gap.
//  TX FSM: IDLE -> SEND(idx 0..len-1) -> IDLE or SEND of pending response.
//   Advance idx only on o_tx_valid & i_tx_ready; o_tx_valid stays 1 through the whole response
//   while ready is high (one byte per cycle max).
//  o_err_cnt saturates at 16'hFFFF. o_busy = (state!=IDLE) | pending_full.
// STRUCTURE
//  Package ft232h_cmd_pkg: OP_WRITE=2'b00, OP_READ=2'b01, RESP_LEN_RD=5, RESP_LEN_ACK=1,
//   response record {len[2:0], bytes[39:0]}.
//  Sub-module ft232h_resp_serializer: 2-entry response buffer + byte handshake FSM.
//   Top keeps decode, register bank, strobes and error counter.
// TESTING
//  WRITE cmd=0x03 data=0xDEADBEEF -> reg3=0xDEADBEEF, wr_stb=16'h0008 for 1 cycle, tx byte 0x03.
//  READ cmd=0x43 with ready=1 -> bytes 0x43,DE,AD,BE,EF on 5 consecutive cycles.
//  READ with ready toggling 1/0 -> each byte held stable until accepted; order unchanged.
//  ready=0, three READs back-to-back -> first two responses sent in order, third dropped,
//    err_cnt=1, o_busy high until second response drains.
//  cmd=0x83, and cmd=0x1F with NREG=16 -> no reg change, no tx, err_cnt +2 total.
//  READ, then i_rst after byte 2 accepted -> o_tx_valid=0, regs=0, no further bytes;
//    a new READ of reg0 returns 0x40,00,00,00,00.

Source files
------------

// File: rtl/ft232h_cmd_pkg.sv
// ft232h_cmd_pkg: opcodes, response lengths and the response record shared by dispatch and serializer
package ft232h_cmd_pkg;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [2:0] RESP_LEN_RD = 3'd5;
  localparam logic [2:0] RESP_LEN_ACK = 3'd1;
  typedef struct packed {
    logic [2:0] len;
    logic [39:0] bytes;
  } resp_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
endpackage

// File: rtl/ft232h_cmd_dispatch_if.sv
// ft232h_cmd_dispatch_if: packet input and response byte handshake between host side and dispatcher
interface ft232h_cmd_dispatch_if;
  logic [7:0] cmd;
  logic [31:0] data;
  logic data_ready;
  logic [7:0] tx_byte;
  logic tx_valid;
  logic tx_ready;
  modport master (output cmd, data, data_ready, tx_ready, input tx_byte, tx_valid);
  modport slave (input cmd, data, data_ready, tx_ready, output tx_byte, tx_valid);
endinterface

// File: rtl/ft232h_resp_serializer.sv
// ft232h_resp_serializer: one active response plus one pending slot, shifted out MSB byte first
module ft232h_resp_serializer
  import ft232h_cmd_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       push,
  input  resp_t      resp,
  output logic       drop,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);
  tx_state_t state, state_n;
  logic [39:0] sh, sh_n;
  logic [2:0] rem, rem_n;
  resp_t pend, pend_n;
  logic pend_v, pend_v_n, fire, last;
  assign tx_byte = sh[39:32];
  assign tx_valid = state == TX_SEND;
  assign busy = state != TX_IDLE || pend_v;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= TX_IDLE;
      sh <= '0;
      rem <= '0;
      pend <= '0;
      pend_v <= 1'b0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      rem <= rem_n;
      pend <= pend_n;
      pend_v <= pend_v_n;
    end
  end
  // On the last accepted byte the next response loads without an idle cycle
  always_comb begin
    state_n = state;
    sh_n = sh;
    rem_n = rem;
    pend_n = pend;
    pend_v_n = pend_v;
    fire = state == TX_SEND && tx_ready;
    last = fire && rem == 3'd1;
    drop = push && pend_v && !last;
    if (state == TX_IDLE) begin
      if (push) begin
        state_n = TX_SEND;
        sh_n = resp.bytes;
        rem_n = resp.len;
      end
    end else if (last) begin
      if (pend_v) begin
        sh_n = pend.bytes;
        rem_n = pend.len;
        pend_n = resp;
        pend_v_n = push;
      end else if (push) begin
        sh_n = resp.bytes;
        rem_n = resp.len;
      end else begin
        state_n = TX_IDLE;
        sh_n = sh << 8;
        rem_n = '0;
      end
    end else begin
      if (fire) begin
        sh_n = sh << 8;
        rem_n = rem - 3'd1;
      end
      if (push && !pend_v) begin
        pend_n = resp;
        pend_v_n = 1'b1;
      end
    end
  end
endmodule

// File: rtl/ft232h_cmd_dispatch.sv
// ft232h_cmd_dispatch: decodes host packets into register bank writes/read-backs and queues byte responses
module ft232h_cmd_dispatch
  import ft232h_cmd_pkg::*;
#(
  parameter int NREG = 16,
  parameter int ADDR_W = 4,
  parameter bit ACK_EN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ft232h_cmd_dispatch_if.slave bus,
  output logic [NREG*32-1:0]   o_reg_flat,
  output logic [NREG-1:0]      o_reg_wr_stb,
  output logic                 o_busy,
  output logic [15:0]          o_err_cnt
);
  logic [ADDR_W-1:0] addr;
  logic [1:0] op;
  logic ok, wr, rd, push, drop;
  resp_t resp;
  always_comb begin
    addr = bus.cmd[ADDR_W-1:0];
    op = bus.cmd[7:6];
    ok = bus.data_ready && (bus.cmd[5:0] >> ADDR_W) == 6'd0 && int'(addr) < NREG;
    wr = ok && op == OP_WRITE;
    rd = ok && op == OP_READ;
    push = rd || (wr && ACK_EN);
    resp = rd ? {RESP_LEN_RD, bus.cmd, o_reg_flat[32*int'(addr) +: 32]} : {RESP_LEN_ACK, bus.cmd, 32'h0};
  end
  // Rejected packets and dropped responses share one saturating counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_reg_flat <= '0;
      o_reg_wr_stb <= '0;
      o_err_cnt <= '0;
    end else begin
      o_reg_wr_stb <= wr ? NREG'(1) << addr : '0;
      if (wr) o_reg_flat[32*int'(addr) +: 32] <= bus.data;
      if (((bus.data_ready && !(wr || rd)) || drop) && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
  ft232h_resp_serializer u_ser (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .push(push),
    .resp(resp),
    .drop(drop),
    .tx_byte(bus.tx_byte),
    .tx_valid(bus.tx_valid),
    .tx_ready(bus.tx_ready),
    .busy(o_busy)
  );
endmodule

// File: tb/tb_ft232h_cmd_dispatch.sv
// tb_ft232h_cmd_dispatch: directed packets against a queue-level response model, compared every cycle
module tb_ft232h_cmd_dispatch;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [511:0] o_reg_flat;
  logic [15:0] o_reg_wr_stb;
  logic o_busy;
  logic [15:0] o_err_cnt;
  int checks = 0;
  int failures = 0;
  bq_t bq;
  bq_t got;
  int lq[$];
  logic [31:0] mreg[16];
  logic [15:0] merr;
  logic [15:0] mstb;
  ft232h_cmd_dispatch_if bus();
  ft232h_cmd_dispatch #(.NREG(16), .ADDR_W(4), .ACK_EN(1'b1)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_reg_flat(o_reg_flat),
    .o_reg_wr_stb(o_reg_wr_stb),
    .o_busy(o_busy),
    .o_err_cnt(o_err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_got(input string nm, input bq_t e);
    chk({nm, "_count"}, 32'(got.size()), 32'(e.size()));
    foreach (e[i]) if (i < got.size()) chk(nm, 32'(got[i]), 32'(e[i]));
    got.delete();
  endtask
  task automatic pkt(input logic [7:0] c, input logic [31:0] d);
    bus.cmd = c;
    bus.data = d;
    bus.data_ready = 1'b1;
    @(negedge clk);
    bus.data_ready = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Model: responses are byte queues; at most two may be outstanding after this edge's accept
  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      lq.delete();
      foreach (mreg[k]) mreg[k] = '0;
      merr = '0;
      mstb = '0;
    end else begin
      mstb = '0;
      if (bq.size() > 0 && bus.tx_ready) begin
        void'(bq.pop_front());
        lq[0] = lq[0] - 1;
        if (lq[0] == 0) void'(lq.pop_front());
      end
      if (bus.data_ready) begin
        if (bus.cmd[7] || bus.cmd[5:4] != 2'b00) begin
          if (merr != 16'hFFFF) merr = merr + 16'd1;
        end else if (lq.size() >= 2) begin
          if (!bus.cmd[6]) begin
            mreg[bus.cmd[3:0]] = bus.data;
            mstb = 16'(1) << bus.cmd[3:0];
          end
          if (merr != 16'hFFFF) merr = merr + 16'd1;
        end else if (bus.cmd[6]) begin
          bq.push_back(bus.cmd);
          for (int b = 3; b >= 0; b--) bq.push_back(mreg[bus.cmd[3:0]][8*b +: 8]);
          lq.push_back(5);
        end else begin
          mreg[bus.cmd[3:0]] = bus.data;
          mstb = 16'(1) << bus.cmd[3:0];
          bq.push_back(bus.cmd);
          lq.push_back(1);
        end
      end
    end
  end
  always @(posedge clk) if (!rst && bus.tx_valid === 1'b1 && bus.tx_ready) got.push_back(bus.tx_byte);
  always @(negedge clk) if (run) begin
    chk("tx_valid", 32'(bus.tx_valid), 32'(bq.size() > 0));
    chk("tx_byte", 32'(bus.tx_byte), bq.size() > 0 ? 32'(bq[0]) : 32'h0);
    chk("busy", 32'(o_busy), 32'(lq.size() > 0));
    chk("err_cnt", 32'(o_err_cnt), 32'(merr));
    chk("wr_stb", 32'(o_reg_wr_stb), 32'(mstb));
    for (int k = 0; k < 16; k++) chk("reg", o_reg_flat[32*k +: 32], mreg[k]);
  end
  initial begin
    bus.cmd = '0;
    bus.data = '0;
    bus.data_ready = 1'b0;
    bus.tx_ready = 1'b1;
    idle(3);
    run = 1'b1;
    chk("rst_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_err", 32'(o_err_cnt), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    rst = 1'b0;
    idle(1);
    pkt(8'h03, 32'hDEADBEEF);
    chk("wr_reg3", o_reg_flat[96 +: 32], 32'hDEADBEEF);
    chk("wr_stb3", 32'(o_reg_wr_stb), 32'h0008);
    idle(4);
    chk_got("wr_ack", '{8'h03});
    pkt(8'h43, 32'h0);
    idle(8);
    chk_got("rd3", '{8'h43, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    pkt(8'h43, 32'h0);
    for (int i = 0; i < 14; i++) begin
      bus.tx_ready = ~bus.tx_ready;
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
    idle(6);
    chk_got("rd3_toggle", '{8'h43, 8'hDE, 8'hAD, 8'hBE, 8'hEF});
    pkt(8'h05, 32'h11223344);
    idle(4);
    chk_got("wr5_ack", '{8'h05});
    bus.tx_ready = 1'b0;
    pkt(8'h43, 32'h0);
    pkt(8'h45, 32'h0);
    pkt(8'h46, 32'h0);
    pkt(8'h07, 32'hCAFEF00D);
    chk("drop_err", 32'(o_err_cnt), 32'h2);
    chk("drop_wr7", o_reg_flat[224 +: 32], 32'hCAFEF00D);
    idle(3);
    chk("drop_busy", 32'(o_busy), 32'h1);
    bus.tx_ready = 1'b1;
    idle(14);
    chk("drain_busy", 32'(o_busy), 32'h0);
    chk_got("two_rd", '{8'h43, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h45, 8'h11, 8'h22, 8'h33, 8'h44});
    pkt(8'h83, 32'h12345678);
    pkt(8'h1F, 32'h12345678);
    idle(4);
    chk("bad_err", 32'(o_err_cnt), 32'h4);
    chk_got("bad_none", '{});
    pkt(8'h43, 32'h0);
    idle(3);
    rst = 1'b1;
    bus.tx_ready = 1'b0;
    idle(1);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(bus.tx_valid), 32'h0);
    chk("rst_mid_reg3", o_reg_flat[96 +: 32], 32'h0);
    chk("rst_mid_err", 32'(o_err_cnt), 32'h0);
    bus.tx_ready = 1'b1;
    idle(3);
    chk("rst_mid_silent", 32'(got.size()), 32'h3);
    pkt(8'h40, 32'h0);
    idle(8);
    chk_got("rst_rd0", '{8'h43, 8'hDE, 8'hAD, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
